// File: rtl/uart_pkg.sv
// Shared UART definitions: parity/state enums, receive config payload, oversample constant.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } uart_rx_state_t;

    typedef struct packed {
        logic [1:0] data_bits_count;
        parity_t    parity;
        logic       double_stop;
    } uart_rx_cfg_t;

    // Register code 2'b11 is a second encoding of "no parity".
    function automatic parity_t decode_parity(input logic [1:0] code);
        case (code)
            2'b01:   return EVEN;
            2'b10:   return ODD;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Generic N-stage flop chain for bringing an asynchronous level into the clk domain.
module synchronizer #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= {STAGES{RESET_VALUE}};
        end else begin
            chain <= STAGES'({chain, d});
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: 16x oversampled, 2-of-3 majority per bit, parity/stop checking,
// one-cycle write strobe per character.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       os_tick,
    input  logic       rx,
    input  logic [1:0] data_bits_count,
    input  logic [1:0] parity_type,
    input  logic       double_stop_bits,
    output logic [7:0] dout,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(OVERSAMPLE / 2 - 2);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic             rx_s;
    logic             rx_prev;
    uart_rx_state_t   state;
    uart_rx_state_t   state_nxt;
    uart_rx_cfg_t     cfg;
    logic [CNT_W-1:0] tick_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             samp_a;
    logic             samp_b;
    logic             pe_acc;
    logic             fe_acc;

    logic [CNT_W-1:0] cnt_now_c;
    logic             maj_c;
    logic             at_mid_c;
    logic             at_end_c;
    logic             start_c;
    logic             last_data_c;
    logic             exp_par_c;
    logic             shift_c;
    logic             par_chk_c;
    logic             stop_chk_c;
    logic             finish_c;

    synchronizer #(
        .STAGES      (2),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // tick_cnt holds the count of the last processed tick; cnt_now_c is this tick's count.
    assign cnt_now_c   = tick_cnt + CNT_W'(1);
    assign maj_c       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign at_mid_c    = os_tick && (cnt_now_c == CNT_MID);
    assign at_end_c    = os_tick && (cnt_now_c == CNT_LAST);
    assign start_c     = os_tick && rx_prev && !rx_s;
    assign last_data_c = (bit_cnt == (4'(cfg.data_bits_count) + 4'd5));
    assign exp_par_c   = (^shreg) ^ (cfg.parity == ODD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shift_c    = 1'b0;
        par_chk_c  = 1'b0;
        stop_chk_c = 1'b0;
        finish_c   = 1'b0;
        case (state)
            IDLE: begin
                if (start_c) state_nxt = START;
            end
            START: begin
                if (at_mid_c && maj_c) begin
                    state_nxt = IDLE;
                end else if (at_end_c) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                shift_c = at_mid_c;
                if (at_end_c && last_data_c) begin
                    state_nxt = (cfg.parity != NONE) ? PARITY : STOP1;
                end
            end
            PARITY: begin
                par_chk_c = at_mid_c;
                if (at_end_c) state_nxt = STOP1;
            end
            STOP1: begin
                stop_chk_c = at_mid_c;
                if (at_mid_c && !cfg.double_stop) begin
                    finish_c  = 1'b1;
                    state_nxt = IDLE;
                end else if (at_end_c) begin
                    state_nxt = STOP2;
                end
            end
            STOP2: begin
                stop_chk_c = at_mid_c;
                if (at_mid_c) begin
                    finish_c  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_prev    <= 1'b1;
            cfg        <= '0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            samp_a     <= 1'b0;
            samp_b     <= 1'b0;
            pe_acc     <= 1'b0;
            fe_acc     <= 1'b0;
            dout       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            busy  <= (state_nxt != IDLE);
            if (os_tick) rx_prev <= rx_s;

            // Config is frozen at the start edge so mid-frame writes cannot corrupt the frame.
            if (state == IDLE) begin
                if (start_c) begin
                    cfg      <= '{data_bits_count: data_bits_count,
                                  parity:          decode_parity(parity_type),
                                  double_stop:     double_stop_bits};
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    shreg    <= '0;
                    pe_acc   <= 1'b0;
                    fe_acc   <= 1'b0;
                end
            end else if (os_tick) begin
                tick_cnt <= cnt_now_c;
                if (cnt_now_c == CNT_S0) samp_a <= rx_s;
                if (cnt_now_c == CNT_S1) samp_b <= rx_s;
            end

            if (shift_c) begin
                shreg   <= {maj_c, shreg[7:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (par_chk_c) pe_acc <= (maj_c != exp_par_c);
            if (stop_chk_c && !maj_c) fe_acc <= 1'b1;

            // Data enters at the MSB, so short characters are right-aligned on output.
            if (finish_c) begin
                dout       <= shreg >> (4'd8 - bit_cnt);
                parity_err <= pe_acc;
                frame_err  <= fe_acc | ~maj_c;
                valid      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a bit-level model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       os_tick = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] data_bits_count = 2'd3;
    logic [1:0] parity_type = 2'd0;
    logic       double_stop_bits = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx dut (
        .clk              (clk),
        .reset            (reset),
        .os_tick          (os_tick),
        .rx               (rx),
        .data_bits_count  (data_bits_count),
        .parity_type      (parity_type),
        .double_stop_bits (double_stop_bits),
        .dout             (dout),
        .valid            (valid),
        .parity_err       (parity_err),
        .frame_err        (frame_err),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int div = 0;
    always @(negedge clk) begin
        div     = (div + 1) % 4;
        os_tick = (div == 0);
    end

    int   tick_cnt = 0;
    logic tick_edge = 1'b0;
    always @(posedge clk) begin
        tick_edge <= os_tick;
        if (os_tick) tick_cnt <= tick_cnt + 1;
    end

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         due;
    } exp_t;

    exp_t exp_arr [0:127];
    int   wr_idx = 0;
    int   rd_idx = 0;
    int   vectors = 0;
    int   errors = 0;
    int   hand_mode = 0;

    logic fb [0:15];
    int   flen = 0;

    // One compare process: valid strobe every cycle, payload when due, plus hand-pinned checks.
    always @(negedge clk) begin
        logic exp_v;
        exp_t e;
        exp_v = (rd_idx < wr_idx) && tick_edge && (tick_cnt == exp_arr[rd_idx].due);
        vectors++;
        if (valid !== exp_v) begin
            errors++;
            $display("FAIL valid_strobe tick %0d: got %b want %b", tick_cnt, valid, exp_v);
        end
        if (exp_v) begin
            e = exp_arr[rd_idx];
            rd_idx++;
            vectors++;
            if ({dout, parity_err, frame_err} !== {e.d, e.pe, e.fe}) begin
                errors++;
                $display("FAIL char tick %0d: got dout=%h pe=%b fe=%b want dout=%h pe=%b fe=%b",
                         tick_cnt, dout, parity_err, frame_err, e.d, e.pe, e.fe);
            end
        end
        case (hand_mode)
            1: begin
                vectors++;
                if ({dout, valid, parity_err, frame_err, busy} !== 12'h000) begin
                    errors++;
                    $display("FAIL reset_state: got dout=%h v=%b pe=%b fe=%b busy=%b want all 0",
                             dout, valid, parity_err, frame_err, busy);
                end
            end
            2: begin
                vectors++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_high tick %0d: got %b want 1", tick_cnt, busy);
                end
            end
            3: begin
                vectors++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_low tick %0d: got %b want 0", tick_cnt, busy);
                end
            end
            4: begin
                vectors++;
                if (wr_idx != rd_idx) begin
                    errors++;
                    $display("FAIL pending_chars: got %0d outstanding want 0", wr_idx - rd_idx);
                end
            end
            default: ;
        endcase
    end

    task automatic hand(input int m);
        hand_mode = m;
        @(negedge clk);
        #1;
        hand_mode = 0;
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (os_tick !== 1'b1);
        #1;
    endtask

    task automatic drive_level(input logic lv, input int n);
        repeat (n) begin
            wait_tick();
            rx = lv;
        end
    endtask

    // Line image of one frame: start, data LSB first, optional parity, stop bit(s).
    function automatic void build(input logic [7:0] data, input int nd, input logic [1:0] pt,
                                  input bit ns2, input bit flip_par, input logic [1:0] stop_bad);
        logic p;
        p    = 1'b0;
        flen = 0;
        fb[flen] = 1'b0;
        flen++;
        for (int i = 0; i < nd; i++) begin
            fb[flen] = data[i];
            p        = p ^ data[i];
            flen++;
        end
        if (pt == 2'b01 || pt == 2'b10) begin
            fb[flen] = p ^ (pt == 2'b10) ^ flip_par;
            flen++;
        end
        fb[flen] = ~stop_bad[0];
        flen++;
        if (ns2) begin
            fb[flen] = ~stop_bad[1];
            flen++;
        end
    endfunction

    // Decode the line image by counting ones: even parity wants an even total incl. parity bit.
    function automatic exp_t model(input int nd, input logic [1:0] pt, input bit ns2);
        exp_t e;
        int   k;
        int   ones;
        e.d  = 8'h00;
        e.pe = 1'b0;
        e.due = 0;
        ones = 0;
        for (int i = 0; i < nd; i++) begin
            e.d[i] = fb[1 + i];
            ones  += int'(fb[1 + i]);
        end
        k = 1 + nd;
        if (pt == 2'b01 || pt == 2'b10) begin
            ones += int'(fb[k]);
            e.pe = (pt == 2'b01) ? (ones % 2 != 0) : (ones % 2 == 0);
            k++;
        end
        e.fe = (fb[k] == 1'b0) || (ns2 && fb[k + 1] == 1'b0);
        return e;
    endfunction

    function automatic exp_t lit(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d   = d;
        e.pe  = pe;
        e.fe  = fe;
        e.due = 0;
        return e;
    endfunction

    // Each bit lasts 16 ticks; the start is seen on the tick after rx falls.
    task automatic drive_frame(input logic [1:0] dbc, input logic [1:0] pt, input logic ds,
                               input exp_t e, input int gj, input int gc);
        wait_tick();
        rx               = fb[0];
        data_bits_count  = dbc;
        parity_type      = pt;
        double_stop_bits = ds;
        e.due = tick_cnt + 1 + 16 * (flen - 1) + 8;
        exp_arr[wr_idx] = e;
        wr_idx++;
        for (int j = 0; j < flen; j++) begin
            for (int c = 0; c < 16; c++) begin
                if (j == 0 && c == 0) continue;
                wait_tick();
                if (j == 2 && c == 0) begin
                    data_bits_count  = 2'($urandom);
                    parity_type      = 2'($urandom);
                    double_stop_bits = 1'($urandom);
                end
                rx = (j == gj && c == gc) ? ~fb[j] : fb[j];
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] data;
        logic [1:0] pt;
        logic [1:0] sb;
        bit         ns2;
        bit         flip;
        bit         last_low;
        int         nd;
        int         gj;
        int         gc;
        exp_t       e;

        repeat (5) @(posedge clk);
        #1;
        hand(1);
        reset = 1'b1;
        drive_level(1'b1, 4);

        // 8N1 0xA5
        build(8'hA5, 8, 2'b00, 1'b0, 1'b0, 2'b00);
        drive_frame(2'd3, 2'b00, 1'b0, lit(8'hA5, 1'b0, 1'b0), -1, -1);

        // 7E2 0x35 with wrong parity bit
        build(8'h35, 7, 2'b01, 1'b1, 1'b1, 2'b00);
        drive_frame(2'd2, 2'b01, 1'b1, lit(8'h35, 1'b1, 1'b0), -1, -1);

        // 8N1 0x3C with low stop, then a held-low break
        build(8'h3C, 8, 2'b00, 1'b0, 1'b0, 2'b01);
        drive_frame(2'd3, 2'b00, 1'b0, lit(8'h3C, 1'b0, 1'b1), -1, -1);
        drive_level(1'b1, 1);
        build(8'h00, 8, 2'b00, 1'b0, 1'b0, 2'b01);
        drive_frame(2'd3, 2'b00, 1'b0, lit(8'h00, 1'b0, 1'b1), -1, -1);
        drive_level(1'b0, 320);
        hand(3);
        drive_level(1'b1, 4);

        // Short low pulse: false start rejected at count 8
        drive_level(1'b0, 5);
        drive_level(1'b1, 4);
        hand(2);
        drive_level(1'b1, 1);
        hand(3);
        drive_level(1'b1, 4);

        // Reset during the data bits of 0x55, then a clean 0x0F
        data_bits_count  = 2'd3;
        parity_type      = 2'b00;
        double_stop_bits = 1'b0;
        build(8'h55, 8, 2'b00, 1'b0, 1'b0, 2'b00);
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < 16; c++) begin
                wait_tick();
                rx = fb[j];
            end
        end
        hand(2);
        reset = 1'b0;
        rx    = 1'b1;
        hand(1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        drive_level(1'b1, 20);
        build(8'h0F, 8, 2'b00, 1'b0, 1'b0, 2'b00);
        drive_frame(2'd3, 2'b00, 1'b0, lit(8'h0F, 1'b0, 1'b0), -1, -1);

        // 5O1 back-to-back 0x1F then 0x00 (config scrambled mid-frame)
        build(8'h1F, 5, 2'b10, 1'b0, 1'b0, 2'b00);
        drive_frame(2'd0, 2'b10, 1'b0, lit(8'h1F, 1'b0, 1'b0), -1, -1);
        build(8'h00, 5, 2'b10, 1'b0, 1'b0, 2'b00);
        drive_frame(2'd0, 2'b10, 1'b0, lit(8'h00, 1'b0, 1'b0), -1, -1);

        // Random frames with optional single-sample glitches
        last_low = 1'b0;
        for (int n = 0; n < 30; n++) begin
            nd   = 5 + int'($urandom_range(3));
            pt   = 2'($urandom);
            ns2  = 1'($urandom);
            flip = 1'($urandom);
            sb   = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            data = 8'($urandom);
            build(data, nd, pt, ns2, flip, sb);
            e  = model(nd, pt, ns2);
            gj = ($urandom_range(1) == 1) ? int'($urandom_range(flen - 2)) : -1;
            gc = int'($urandom_range(8, 6));
            if (last_low || $urandom_range(2) == 0) drive_level(1'b1, 1 + int'($urandom_range(2)));
            drive_frame(2'(nd - 5), pt, ns2, e, gj, gc);
            last_low = (fb[flen - 1] == 1'b0);
        end

        drive_level(1'b1, 20);
        hand(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
